// File: rtl/hazard_scoreboard_if.sv
// DU-side hazard scoreboard bundle.
// master drives DU/XU status; slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
);
  logic             du_instruct_valid_i;
  logic [5:0]       du_instruct_type_i;
  logic [4:0]       du_rs0_i;
  logic [4:0]       du_rs1_i;
  logic [4:0]       du_rdt_i;
  logic             du_is_load_i;
  logic             du_is_mcyc_i;
  logic             flush_i;
  logic             mcyc_done_i;
  logic             mcyc_kill_i;
  logic             stall_o;
  logic [NREG-1:0]  busy_vec_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output du_instruct_valid_i, du_instruct_type_i,
    output du_rs0_i, du_rs1_i, du_rdt_i,
    output du_is_load_i, du_is_mcyc_i,
    output flush_i, mcyc_done_i, mcyc_kill_i,
    input  stall_o, busy_vec_o, stall_cnt_o
  );

  modport slave (
    input  du_instruct_valid_i, du_instruct_type_i,
    input  du_rs0_i, du_rs1_i, du_rdt_i,
    input  du_is_load_i, du_is_mcyc_i,
    input  flush_i, mcyc_done_i, mcyc_kill_i,
    output stall_o, busy_vec_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use and multi-cycle-op scoreboard beside DU.
// Stalls DU until in-flight results become forwardable.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  hazard_scoreboard_if.slave hz
);

  logic [NREG-1:0]  ld_q, ld_d;
  logic             mc_busy_q, mc_busy_d;
  logic [4:0]       mc_rdt_q, mc_rdt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREG-1:0]  blk;
  logic [5:0]       ty;
  logic             uses_rs, uses_rs1, writes_rd;
  logic             raw0, raw1, waw, strct;
  logic             stall, issue;

  assign ty        = hz.du_instruct_type_i;
  assign uses_rs   = |ty[5:2];
  assign uses_rs1  = ty[5] | ty[3] | ty[2];
  assign writes_rd = (ty[5] | ty[4] | ty[1] | ty[0])
                   & (hz.du_rdt_i != 5'd0);

  always_comb begin
    blk = '0;
    for (int r = 0; r < NREG; r++) begin
      blk[r] = ld_q[r]
             | (mc_busy_q && (mc_rdt_q == 5'(r)));
    end
    blk[0] = 1'b0;
  end

  assign raw0  = uses_rs  & blk[hz.du_rs0_i];
  assign raw1  = uses_rs1 & blk[hz.du_rs1_i];
  assign waw   = writes_rd & mc_busy_q
               & (mc_rdt_q == hz.du_rdt_i);
  assign strct = hz.du_is_mcyc_i & mc_busy_q
               & ~hz.mcyc_done_i;

  assign stall = hz.du_instruct_valid_i & ~hz.flush_i
               & (raw0 | raw1 | waw | strct);
  assign issue = hz.du_instruct_valid_i & ~stall
               & ~hz.flush_i;

  // One-cycle countdown: a load result is forwardable from MEM.
  always_comb begin
    ld_d = '0;
    if (issue && hz.du_is_load_i && writes_rd) begin
      ld_d[hz.du_rdt_i] = 1'b1;
    end
  end

  // A new mcyc issue on the done cycle wins over the clear.
  always_comb begin
    mc_busy_d = mc_busy_q;
    mc_rdt_d  = mc_rdt_q;
    if (hz.mcyc_kill_i || hz.mcyc_done_i) begin
      mc_busy_d = 1'b0;
    end
    if (issue && hz.du_is_mcyc_i && writes_rd) begin
      mc_busy_d = 1'b1;
      mc_rdt_d  = hz.du_rdt_i;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_q      <= '0;
      mc_busy_q <= 1'b0;
      mc_rdt_q  <= 5'd0;
      cnt_q     <= '0;
    end else begin
      ld_q      <= ld_d;
      mc_busy_q <= mc_busy_d;
      mc_rdt_q  <= mc_rdt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hz.stall_o     = stall;
  assign hz.busy_vec_o  = blk;
  assign hz.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Table of per-cycle vectors plus multi-cycle sequences.
module tb_hazard_scoreboard;

  localparam logic [5:0] TR = 6'b100000;
  localparam logic [5:0] TI = 6'b010000;
  localparam logic [5:0] TS = 6'b001000;
  localparam logic [5:0] TB = 6'b000100;
  localparam logic [5:0] TU = 6'b000010;
  localparam logic [5:0] TJ = 6'b000001;

  typedef struct {
    logic        v;
    logic [5:0]  ty;
    logic [4:0]  rs0, rs1, rd;
    logic        ld, mc, fl, dn, kl;
    logic        st;
    logic [31:0] bv;
    logic [15:0] cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t tbl[$];

  hazard_scoreboard_if #(.NREG(32), .CNT_W(16)) hz ();

  hazard_scoreboard #(.NREG(32), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] b(input int r);
    return 32'd1 << r;
  endfunction

  function automatic vec_t mk(
    input logic v, input logic [5:0] ty,
    input logic [4:0] rs0, input logic [4:0] rs1,
    input logic [4:0] rd,
    input logic ld, input logic mc, input logic fl,
    input logic dn, input logic kl,
    input logic st, input logic [31:0] bv,
    input logic [15:0] cnt);
    vec_t t;
    t.v = v; t.ty = ty; t.rs0 = rs0; t.rs1 = rs1;
    t.rd = rd; t.ld = ld; t.mc = mc; t.fl = fl;
    t.dn = dn; t.kl = kl; t.st = st; t.bv = bv;
    t.cnt = cnt;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    hz.du_instruct_valid_i = t.v;
    hz.du_instruct_type_i  = t.ty;
    hz.du_rs0_i            = t.rs0;
    hz.du_rs1_i            = t.rs1;
    hz.du_rdt_i            = t.rd;
    hz.du_is_load_i        = t.ld;
    hz.du_is_mcyc_i        = t.mc;
    hz.flush_i             = t.fl;
    hz.mcyc_done_i         = t.dn;
    hz.mcyc_kill_i         = t.kl;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic st,
                         input logic [31:0] bv,
                         input logic [15:0] cnt);
    chk({nm, " stall"}, 32'(hz.stall_o), 32'(st));
    chk({nm, " busy"}, hz.busy_vec_o, bv);
    chk({nm, " cnt"}, 32'(hz.stall_cnt_o), 32'(cnt));
  endtask

  vec_t idle, div9, dep9, div3;

  initial begin
    total = 0;
    bad   = 0;
    idle = mk(0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    div9 = mk(1, TR, 1, 2, 9, 0, 1, 0, 0, 0, 0, 0, 0);
    dep9 = mk(1, TR, 9, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    div3 = mk(1, TR, 1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0);

    // load-use: exactly one stall cycle
    tbl.push_back(mk(1,TI,1,0,5,1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,TR,5,1,6,0,0,0,0,0, 1,b(5),0));
    tbl.push_back(mk(1,TR,5,1,6,0,0,0,0,0, 0,0,1));
    tbl.push_back(mk(0,TR,0,0,0,0,0,0,0,0, 0,0,1));
    // unrelated op between load and use
    tbl.push_back(mk(1,TI,2,0,5,1,0,0,0,0, 0,0,1));
    tbl.push_back(mk(1,TR,2,3,7,0,0,0,0,0, 0,b(5),1));
    tbl.push_back(mk(1,TR,5,1,6,0,0,0,0,0, 0,0,1));
    // x0 never tracked
    tbl.push_back(mk(1,TI,1,0,0,1,0,0,0,0, 0,0,1));
    tbl.push_back(mk(1,TR,0,0,1,0,0,0,0,0, 0,0,1));
    // div x9 then addi x9,x9,1; kill releases
    tbl.push_back(mk(1,TR,1,2,9,0,1,0,0,0, 0,0,1));
    tbl.push_back(mk(1,TI,9,0,9,0,0,0,0,0, 1,b(9),1));
    tbl.push_back(mk(1,TI,9,0,9,0,0,0,0,1, 1,b(9),2));
    tbl.push_back(mk(1,TI,9,0,9,0,0,0,0,0, 0,0,3));
    // store uses rs1; I-type ignores rs1
    tbl.push_back(mk(1,TI,1,0,5,1,0,0,0,0, 0,0,3));
    tbl.push_back(mk(1,TS,2,5,5,0,0,0,0,0, 1,b(5),3));
    tbl.push_back(mk(1,TS,2,5,5,0,0,0,0,0, 0,0,4));
    tbl.push_back(mk(1,TI,1,0,5,1,0,0,0,0, 0,0,4));
    tbl.push_back(mk(1,TI,2,5,7,0,0,0,0,0, 0,b(5),4));
    // flush squashes stall and the load
    tbl.push_back(mk(1,TI,1,0,5,1,0,0,0,0, 0,0,4));
    tbl.push_back(mk(1,TR,5,1,6,0,0,1,0,0, 0,b(5),4));
    tbl.push_back(mk(0,TR,5,1,6,0,0,0,0,0, 0,0,4));
    // structural: second div issues on done cycle
    tbl.push_back(mk(1,TR,1,2,9,0,1,0,0,0, 0,0,4));
    tbl.push_back(mk(1,TR,1,2,3,0,1,0,0,0, 1,b(9),4));
    tbl.push_back(mk(1,TR,1,2,3,0,1,0,0,0, 1,b(9),5));
    tbl.push_back(mk(1,TR,1,2,3,0,1,0,1,0, 0,b(9),6));
    tbl.push_back(mk(0,TR,0,0,0,0,0,0,0,0, 0,b(3),6));
    // U/J WAW against mc_rdt
    tbl.push_back(mk(1,TU,0,0,3,0,0,0,0,0, 1,b(3),6));
    tbl.push_back(mk(1,TJ,0,0,3,0,0,0,0,1, 1,b(3),7));
    tbl.push_back(mk(1,TJ,0,0,3,0,0,0,0,0, 0,0,8));
    // branch rd field never matches
    tbl.push_back(mk(1,TR,1,2,9,0,1,0,0,0, 0,0,8));
    tbl.push_back(mk(1,TB,1,2,9,0,0,0,0,0, 0,b(9),8));
    tbl.push_back(mk(0,TR,0,0,0,0,0,0,1,0, 0,b(9),8));
    tbl.push_back(mk(0,TR,0,0,0,0,0,0,0,0, 0,0,8));
    // div to x0 sets no busy
    tbl.push_back(mk(1,TR,1,2,0,0,1,0,0,0, 0,0,8));
    tbl.push_back(mk(1,TR,0,0,1,0,0,0,0,0, 0,0,8));
    // invalid DU never stalls
    tbl.push_back(mk(1,TR,1,2,9,0,1,0,0,0, 0,0,8));
    tbl.push_back(mk(0,TR,9,0,4,0,0,0,0,0, 0,b(9),8));
    tbl.push_back(mk(1,TR,9,0,4,0,0,0,0,1, 1,b(9),8));
    tbl.push_back(mk(1,TR,9,0,4,0,0,0,0,0, 0,0,9));

    rst = 1'b1;
    drive(idle);
    step();
    step();
    rst = 1'b0;
    #2;
    chk_all("reset", 0, 0, 0);
    step();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #2;
      chk_all($sformatf("v%0d", i), tbl[i].st, tbl[i].bv,
              tbl[i].cnt);
      step();
    end

    // reset while a div is outstanding
    drive(div9);
    step();
    drive(dep9);
    #2;
    chk("midrst pre stall", 32'(hz.stall_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(idle);
    #2;
    chk_all("midrst post", 0, 0, 0);
    step();

    // div with done 10 cycles after issue
    drive(div9);
    step();
    drive(dep9);
    for (int c = 1; c <= 10; c++) begin
      hz.mcyc_done_i = (c == 10);
      #2;
      chk($sformatf("div c%0d stall", c),
          32'(hz.stall_o), 32'd1);
      step();
    end
    hz.mcyc_done_i = 1'b0;
    #2;
    chk_all("div release", 0, 0, 10);
    step();

    // second div on the done cycle keeps busy with new tag
    drive(div9);
    step();
    drive(div3);
    hz.mcyc_done_i = 1'b1;
    #2;
    chk("div2 done stall", 32'(hz.stall_o), 32'd0);
    step();
    drive(idle);
    #2;
    chk("div2 busy", hz.busy_vec_o, b(3));
    hz.mcyc_kill_i = 1'b1;
    step();
    hz.mcyc_kill_i = 1'b0;

    // counter saturation
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(div9);
    step();
    drive(dep9);
    for (int c = 0; c < 65534; c++) step();
    #2;
    chk("sat 65534", 32'(hz.stall_cnt_o), 32'd65534);
    step();
    #2;
    chk("sat 65535", 32'(hz.stall_cnt_o), 32'd65535);
    for (int c = 0; c < 5; c++) step();
    #2;
    chk_all("sat hold", 1, b(9), 16'hffff);
    hz.mcyc_kill_i = 1'b1;
    step();
    drive(idle);
    #2;
    chk("sat kill busy", hz.busy_vec_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the operand forwarding path in the 5-stage core (DU/XU/MEM/WBU).
- Tracks in-flight register writes that are not yet forwardable and stalls DU until they are:
  - load-use: a load's result is forwardable only once the load reaches MEM;
  - multi-cycle XU ops (div/rem): busy until XU signals completion.
- Sits beside DU. `stall_o` freezes the PC/IF/DU pipeline registers and injects a bubble into XU.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous reset, active-high
- du_instruct_valid_i  input  1  DU holds a valid instruction
- du_instruct_type_i  input  6  one-hot type: bit5 R, bit4 I, bit3 S, bit2 B, bit1 U, bit0 J
- du_rs0_i  input  5  source register 0
- du_rs1_i  input  5  source register 1
- du_rdt_i  input  5  destination register
- du_is_load_i  input  1  DU instruction is a load
- du_is_mcyc_i  input  1  DU instruction is a multi-cycle XU op
- flush_i  input  1  pipeline flush from branch/jump resolution
- mcyc_done_i  input  1  multi-cycle op completes this cycle (result enters MEM next cycle)
- mcyc_kill_i  input  1  abort the outstanding multi-cycle op
- stall_o  output  1  hold DU, bubble XU
- busy_vec_o  output NREG  per-register blocked flag (debug/trace)
- stall_cnt_o  output CNT_W  cycles with `stall_o`=1, saturating

Behaviour:
- Reset (synchronous, `rst_i`=1 at a rising edge): all load countdowns, the mcyc busy flag and tag, and `stall_cnt_o` clear to 0.
  - Outputs then read `stall_o`=0 and `busy_vec_o`=0.
  - Reset mid-operation discards all tracking; no state survives.
- State:
  - `ld_cnt[r]`, 1 bit per register r=1..NREG-1.
  - `mc_busy`, 1 bit.
  - `mc_rdt`, 5 bits.
- Derived signals:
  - `uses_rs` = type R|I|S|B; `uses_rs0` = `uses_rs`; `uses_rs1` = type R|S|B.
  - `writes_rd` = type R|I|U|J and `du_rdt_i`≠0.
  - `blocked(r)` = r≠0 and (`ld_cnt[r]` or (`mc_busy` and `mc_rdt`==r)).
  - `busy_vec_o[r]` = `blocked(r)`; bit 0 is always 0.
- `stall_o` is combinational from registered state plus DU inputs. It is 1 iff `du_instruct_valid_i` and `!flush_i` and any of:
  - `uses_rs0` and `blocked(du_rs0_i)`;
  - `uses_rs1` and `blocked(du_rs1_i)`;
  - WAW: `writes_rd` and `mc_busy` and `mc_rdt`==`du_rdt_i`;
  - structural: `du_is_mcyc_i` and `mc_busy` and not `mcyc_done_i`.
- Issue: `issue` = `du_instruct_valid_i` & `!stall_o` & `!flush_i`.
- Load countdown, each clock edge:
  - all `ld_cnt` clear (one-cycle countdown);
  - then, if `issue` & `du_is_load_i` & `writes_rd`, set `ld_cnt[du_rdt_i]`=1.
  - Net effect: a dependent directly behind a load stalls exactly 1 cycle.
- Multi-cycle tracking, in priority order:
  - `mcyc_kill_i` or `mcyc_done_i` clears `mc_busy`;
  - an `issue` & `du_is_mcyc_i` & `writes_rd` in the same cycle sets `mc_busy`=1 and `mc_rdt`=`du_rdt_i` (set wins over clear).
  - `du_is_mcyc_i` with rd=x0 issues without setting busy.
- Done-cycle hazard: `mcyc_done_i` in the same cycle as a dependent in DU still stalls that cycle (state is registered). The dependent issues the next cycle and picks up the value via MEM forwarding.
- `flush_i`:
  - suppresses `issue` and forces `stall_o`=0;
  - clears all `ld_cnt` at the edge (any flushed load is squashed);
  - leaves `mc_busy` unchanged; `mcyc_kill_i` governs it.
- `stall_cnt_o` increments by 1 on each edge where `stall_o`=1 and holds at 2^CNT_W−1.
- Operand x0 and S/B/U/J destination fields never create or match hazards.

Test Plan:
- Load x5 issued, next DU `add x6,x5,x1` → `stall_o`=1 for exactly 1 cycle, then 0; `busy_vec_o[5]`=1 during that cycle; `stall_cnt_o`=1.
- Load x5, then unrelated `add x7,x2,x3`, then `add x6,x5,x1` → `stall_o` stays 0 throughout.
- Div x9 issued; dependent `sub x4,x9,x2` in DU → stall held until the cycle `mcyc_done_i`=1 inclusive, released the next cycle. With done 10 cycles after issue, `stall_cnt_o`=10.
- Div x9 outstanding; second div x3 in DU → stall. On the `mcyc_done_i` cycle the second div issues, `mc_busy` stays 1 and `mc_rdt`=3.
- Load x0 then `add x1,x0,x0` → no stall. Div x9 outstanding, `addi x9,x9,1` (WAW+RAW) → stall. `mcyc_kill_i`=1 → stall drops the next cycle.
- Load x5 issued, `flush_i`=1 in the next cycle with dependent in DU → `stall_o`=0 that cycle; `busy_vec_o`=0 the cycle after. Assert `rst_i` while div outstanding → `busy_vec_o`=0 and `stall_cnt_o`=0 after the edge.
